// File: rtl/fifo_uart_pkg.sv
// Shared state encoding and sizing helpers for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_e;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned BIT_IDX_W  = $clog2(DATA_W_DEF);

  // Width of a counter running 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick marks the last clk of a serial bit, pre_tick the clk before it.
module uart_baud_tick
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  localparam int unsigned    CNT_W    = cnt_w(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // Flags are registered from the next count so they align with cnt_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      tick     <= 1'b0;
      pre_tick <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tick     <= (cnt_d == LAST);
      pre_tick <= (cnt_d == PRE_LAST);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from an upstream FIFO and sends each as an LSB-first UART frame
// (start, data, optional parity, one stop bit).
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_re,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int unsigned IDX_W = (DATA_W == DATA_W_DEF) ? BIT_IDX_W : cnt_w(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic PAR_INV = (PARITY_ODD != 0);
  localparam logic HAS_PAR = (PARITY_EN != 0);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  bit_q, bit_d;
  logic              parity_q, parity_d;
  logic              tx_d, busy_d, fifo_re_d, tx_done_d;
  logic              baud_clr, baud_tick, baud_pre_tick;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clr     (baud_clr),
    .tick    (baud_tick),
    .pre_tick(baud_pre_tick)
  );

  // Next-state logic; outputs are derived from the next state so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    parity_d  = parity_q;
    baud_clr  = 1'b0;
    tx_d      = 1'b1;
    busy_d    = 1'b0;
    fifo_re_d = 1'b0;
    tx_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        baud_clr = 1'b1;
        if (enable && !fifo_empty) begin
          state_d = POP;
        end
      end
      POP: begin
        baud_clr = 1'b1;
        state_d  = LOAD;
      end
      LOAD: begin
        baud_clr = 1'b1;
        shift_d  = fifo_dout;
        parity_d = (^fifo_dout) ^ PAR_INV;
        state_d  = START;
      end
      START: begin
        if (baud_tick) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_IDX) begin
            state_d = HAS_PAR ? PARITY : STOP;
          end else begin
            bit_d = bit_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (baud_tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase

    busy_d    = (state_d != IDLE);
    fifo_re_d = (state_d == POP);
    tx_done_d = (state_q == STOP) && baud_pre_tick;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      parity_q <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      fifo_re  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      parity_q <= parity_d;
      tx       <= tx_d;
      busy     <= busy_d;
      fifo_re  <= fifo_re_d;
      tx_done  <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Three transmitters (no parity, even, odd) fed from identical FIFO models;
// a negedge monitor checks every cycle against a frame-level reference.
module tb_fifo_uart_tx;

  localparam int unsigned CPB = 4;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          enable;
  logic [7:0]    fifo_dout [NI];
  logic [NI-1:0] fifo_empty = '1;
  logic [NI-1:0] fifo_re, tx, busy, tx_done;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fifo_uart_tx #(
      .DATA_W      (8),
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   ((g > 0) ? 1 : 0),
      .PARITY_ODD  ((g == 2) ? 1 : 0)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .fifo_dout (fifo_dout[g]),
      .fifo_empty(fifo_empty[g]),
      .fifo_re   (fifo_re[g]),
      .tx        (tx[g]),
      .busy      (busy[g]),
      .tx_done   (tx_done[g])
    );
  end

  // Upstream FIFO model: data valid the cycle after the read strobe.
  logic       push_v = 1'b0;
  logic [7:0] push_d = '0;
  logic [7:0] fq [NI][$];

  always @(posedge clk) begin : fifo_model
    logic [7:0] b;
    for (int i = 0; i < NI; i++) begin
      if (fifo_re[i] && fq[i].size() > 0) begin
        b = fq[i].pop_front();
        fifo_dout[i] <= b;
      end
      if (push_v) fq[i].push_back(push_d);
      fifo_empty[i] <= (fq[i].size() == 0);
    end
  end

  function automatic int flen(input int inst);
    return ((inst > 0) ? 11 : 10) * CPB;
  endfunction

  // Expected line level idx cycles into a frame, from the frame layout alone.
  function automatic logic exp_bit(input int inst, input logic [7:0] b, input int idx);
    int   bn;
    logic p;
    bn = idx / CPB;
    if (bn == 0) return 1'b0;
    if (bn <= 8) return b[bn-1];
    if (inst > 0 && bn == 9) begin
      p = ($countones(b) % 2) == 1;
      if (inst == 2) p = !p;
      return p;
    end
    return 1'b1;
  endfunction

  int total = 0;
  int bad   = 0;
  int tmo   = 0;
  logic final_chk  = 1'b0;
  logic final_done = 1'b0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s[%0d] @%0t: actual=%0h required=%0h", nm, inst, $time, act, req);
    end
  endtask

  logic [7:0]    exp_q [NI][$];
  logic [7:0]    cur [NI];
  int            pos [NI]     = '{default: -1};
  int            pops [NI]    = '{default: 0};
  int            frames [NI]  = '{default: 0};
  int            aborted [NI] = '{default: 0};
  int            n_push       = 0;
  logic          prev_rst     = 1'b0;
  logic          prev_en      = 1'b0;
  logic [NI-1:0] prev_empty   = '1;

  // pos: -1 idle, 0 pop cycle, 1 load cycle, 2.. frame cycles.
  always @(negedge clk) begin : monitor
    int   p;
    int   ln;
    logic er;
    for (int i = 0; i < NI; i++) begin
      ln = flen(i);
      if (!reset) begin
        chk("rst_tx", i, tx[i], 1);
        chk("rst_busy", i, busy[i], 0);
        chk("rst_fifo_re", i, fifo_re[i], 0);
        chk("rst_tx_done", i, tx_done[i], 0);
        if (pos[i] >= 0) aborted[i]++;
        pos[i] = -1;
      end else begin
        p  = (pos[i] >= 0 && pos[i] < ln + 1) ? pos[i] + 1 : -1;
        er = (p == -1) && (pos[i] == -1) && prev_rst && prev_en && !prev_empty[i];
        chk("fifo_re", i, fifo_re[i], er);
        if (p == -1 && fifo_re[i] === 1'b1) begin
          p = 0;
          pops[i]++;
          chk("sb_has_byte", i, exp_q[i].size() > 0, 1);
          cur[i] = (exp_q[i].size() > 0) ? exp_q[i].pop_front() : 8'h00;
        end
        chk("busy", i, busy[i], p >= 0);
        if (p >= 2) begin
          chk("tx", i, tx[i], exp_bit(i, cur[i], p - 2));
          chk("tx_done", i, tx_done[i], (p - 2) == ln - 1);
        end else begin
          chk("tx", i, tx[i], 1);
          chk("tx_done", i, tx_done[i], 0);
        end
        if (p == ln + 1) frames[i]++;
        pos[i] = p;
      end
    end
    if (push_v) begin
      n_push++;
      for (int i = 0; i < NI; i++) exp_q[i].push_back(push_d);
    end
    prev_rst   = reset;
    prev_en    = enable;
    prev_empty = fifo_empty;
    if (final_chk && !final_done) begin
      for (int i = 0; i < NI; i++) begin
        chk("sb_left", i, exp_q[i].size(), 0);
        chk("fifo_drained", i, fifo_empty[i], 1);
        chk("pop_count", i, pops[i], n_push);
        chk("frames", i, frames[i] + aborted[i], n_push);
        chk("aborted", i, aborted[i], 1);
      end
      chk("timeouts", 0, tmo, 0);
      final_done = 1'b1;
    end
  end

  task automatic push(input logic [7:0] b);
    @(posedge clk); #1;
    push_v = 1'b1;
    push_d = b;
    @(posedge clk); #1;
    push_v = 1'b0;
  endtask

  task automatic wait_idle();
    int stable = 0;
    int n = 0;
    while (stable < 5 && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (busy == '0 && fifo_empty == '1) stable++;
      else stable = 0;
    end
    if (stable < 5) tmo++;
  endtask

  task automatic wait_re0();
    int n = 0;
    while (fifo_re[0] !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (fifo_re[0] !== 1'b1) tmo++;
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b1;
    enable = 1'b1;

    push(8'hA5);
    wait_idle();
    push(8'h07);
    wait_idle();
    push(8'h01);
    push(8'h80);
    wait_idle();

    repeat (100) @(posedge clk);
    push(8'h3C);
    wait_idle();

    // enable drops in the third data bit of 0x55 with 0xAA queued
    push(8'h55);
    push(8'hAA);
    wait_re0();
    repeat (14) @(posedge clk);
    #1 enable = 1'b0;
    repeat (150) @(posedge clk);
    #1 enable = 1'b1;
    wait_idle();

    // reset in the middle of the data bits of 0xF0
    push(8'hF0);
    wait_re0();
    repeat (18) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (80) @(posedge clk);
    wait_idle();

    for (int n = 0; n < 24; n++) begin
      push(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 60)) @(posedge clk);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1 enable = 1'b0;
        repeat ($urandom_range(1, 80)) @(posedge clk);
        #1 enable = 1'b1;
      end
    end
    wait_idle();

    @(posedge clk); #1 final_chk = 1'b1;
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream consumer of the 8-bit FIFO. Pops one byte whenever the FIFO is non-empty and the block is idle and enabled, then serializes it LSB-first as an asynchronous UART frame: start, data, optional parity, one stop bit. Drives the FIFO read strobe directly, which gives the design a byte-buffered serial transmit path.

Parameters:
DATA_W, 8, data/frame width; must match the FIFO width
CLKS_PER_BIT, 16, clk cycles per serial bit; legal >= 2
PARITY_EN, 0, 1 = insert parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd (ignored if PARITY_EN=0)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  permits starting a new frame
fifo_dout  in  DATA_W  FIFO read data; valid the cycle after fifo_re is sampled
fifo_empty  in  1  FIFO empty flag
fifo_re  out  1  FIFO read strobe, one-cycle pulse per byte
tx  out  1  serial line, idle high
busy  out  1  high from POP through the last STOP cycle
tx_done  out  1  one-cycle pulse in the final clk of the stop bit

Behaviour:
- Reset (reset=0, async): state=IDLE, tx=1, fifo_re=0, busy=0, tx_done=0, counters=0. All outputs are registered.
- FSM states: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- IDLE: if enable=1 and fifo_empty=0, go to POP. Otherwise stay. fifo_empty and enable are sampled only in IDLE.
- POP (1 cycle): fifo_re=1. The FIFO samples it at the closing edge.
- LOAD (1 cycle): fifo_re=0. Shift register <= fifo_dout at the closing edge. Parity is computed: XOR of data, inverted if PARITY_ODD.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: DATA_W bits, LSB first, CLKS_PER_BIT cycles each. A bit counter runs 0..DATA_W-1.
- PARITY (only if PARITY_EN): tx=parity for CLKS_PER_BIT cycles.
- STOP: tx=1 for CLKS_PER_BIT cycles. tx_done=1 in its last cycle, then go to IDLE.
- Bit timing: a baud counter counts 0..CLKS_PER_BIT-1. Its terminal count advances the bit or state. The counter clears on entry to START.
- Frame length is (2+DATA_W+PARITY_EN)*CLKS_PER_BIT cycles, measured from the first START cycle.
- Back-to-back frames: the minimum inter-frame idle-high gap is exactly 3 cycles (IDLE, POP, LOAD) after STOP.
- busy=1 in POP, LOAD, START, DATA, PARITY and STOP; busy=0 only in IDLE.
- fifo_re is never asserted while fifo_empty=1 was sampled in IDLE. Exactly one fifo_re pulse occurs per frame.
- enable falling mid-frame: the current frame completes normally and no new pop occurs.
- fifo_empty or fifo_dout changes after LOAD have no effect on the frame in flight.
- Reset mid-frame: tx goes to 1 immediately and the FSM returns to IDLE. A byte already popped is discarded and not retransmitted.
- fifo_dout is not consumed in any state other than LOAD.

Decomposition:
- Package fifo_uart_pkg:
  - state enum (IDLE..STOP), 3-bit encoding
  - localparam for bit-index width, $clog2(DATA_W)
  - baud counter width function, $clog2(CLKS_PER_BIT)
- Sub-module uart_baud_tick:
  - parameter CLKS_PER_BIT; inputs clk, reset, clr; output tick
  - tick is a one-cycle pulse on the terminal count
  - same reset convention as the parent
- Top owns the FSM, shift register, bit counter and parity.

Test Plan:
1. CLKS_PER_BIT=4, PARITY_EN=0, FIFO holds 0xA5, enable=1.
   - fifo_re pulses once, 1 cycle after IDLE.
   - tx shows 0 | 1,0,1,0,0,1,0,1 | 1, each for 4 cycles (40 cycles total).
   - tx_done pulses on cycle 40. busy then falls.
2. PARITY_EN=1, PARITY_ODD=0, byte 0x07: parity bit=1 and the frame is 44 cycles. PARITY_ODD=1 with the same byte: parity bit=0.
3. FIFO holds 0x01 then 0x80: two frames, with tx high for exactly 3 cycles between the stop of frame 1 and the start of frame 2. fifo_re pulses exactly twice, then the FIFO is empty.
4. fifo_empty=1, enable=1 for 100 cycles: fifo_re=0, tx=1, busy=0 throughout. Push 0x3C: a frame starts and the correct byte is sent.
5. Drop enable at the 3rd DATA bit of 0x55: the frame completes and tx_done pulses. A queued byte 0xAA is not popped until enable=1 again.
6. Assert reset during DATA of 0xF0: tx=1 within the same cycle (async), busy=0, fifo_re=0. After release with the FIFO empty, the block stays idle and 0xF0 is not resent.
